// File: rtl/approx_serial_subtractor.sv
// Bit-serial approximate subtractor, A - B - Bin, LSB first.
// Low K cells drop the incoming borrow; upper cells are exact.
module approx_serial_subtractor #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] KLIM = CW'(K);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]  sa, sb;
  logic          br;
  logic [CW-1:0] cnt;
  logic          ai, bi, d, br_nx;
  logic          accept, last;
  logic [N-1:0]  bmask, dbits;

  assign ai     = sa[0];
  assign bi     = sb[0];
  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == LAST);

  always_comb begin
    d     = ai ^ bi ^ br;
    br_nx = ~ai & bi;
    if (cnt >= KLIM)
      br_nx = (~ai & bi) | (~(ai ^ bi) & br);
    bmask = N'(1) << cnt;
    dbits = N'(d) << cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)    state_nx = RUN;
      RUN:  if (last)        state_nx = DONE;
      DONE: if (out_ready)   state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // Operands shift right so the active bit is always at position 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      br   <= bin;
      cnt  <= '0;
      diff <= '0;
    end else if (state == RUN) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      br   <= br_nx;
      diff <= (diff & ~bmask) | dbits;
      if (last) bout <= br_nx;
      else      cnt  <= cnt + 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
